// File: rtl/ram_wr_sdram.sv
// ram_wr_sdram
// ---------------------------------------------------------------------------
// Write-direction staging block between the QSPI write decoder and the SDRAM
// controller write port, in the sdram_clk domain. An 8 x 16-bit staging
// buffer is filled through buf_wen/buf_waddr/buf_wdata while idle. A rising
// edge on qspi_wr_req (which comes from the qspi_clk domain) pushes the buffer
// into the controller as one burst: an address phase, then bl data beats.
//
// Ports:
//   sdram_clk, rst_n             clock and asynchronous active-low reset
//   buf_wen/buf_waddr/buf_wdata  staging-buffer write port (accepted in IDLE only)
//   qspi_wr_req, qspi_wr_addr    write request level (async) and byte address
//   qspi_wr_len                  burst length, only when WR_LEN_EN is defined
//   qspi_wr_busy                 high while a burst is in progress
//   wr_done                      one-cycle pulse after the last beat is accepted
//   wr_addr/wr_avalid/wr_aready  SDRAM word address channel
//   wr_data/wr_valid/wr_ready    SDRAM write data channel
//
// Configuration macro: WR_LEN_EN. When defined, qspi_wr_len is captured with
// the address and selects the burst length (0 or >8 means 8). When undefined
// the burst length is the WR_BL parameter.
// ---------------------------------------------------------------------------
module ram_wr_sdram #(
  parameter int WR_BL = 8
) (
  input  logic        sdram_clk,
  input  logic        rst_n,
  input  logic        buf_wen,
  input  logic [2:0]  buf_waddr,
  input  logic [15:0] buf_wdata,
  input  logic        qspi_wr_req,
  input  logic [23:0] qspi_wr_addr,
`ifdef WR_LEN_EN
  input  logic [3:0]  qspi_wr_len,
`endif
  output logic        qspi_wr_busy,
  output logic        wr_done,
  output logic [23:0] wr_addr,
  output logic        wr_avalid,
  input  logic        wr_aready,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  wr_cnt_r;
  logic [15:0] buf_r [8];

  // Request synchroniser: req_meta_r absorbs metastability, req0_r/req1_r
  // are the settled level and its one-cycle-delayed copy for edge detection.
  logic req_meta_r;
  logic req0_r;
  logic req1_r;
  logic start_s;

  logic [3:0] bl_s;
  logic       beat_s;
  logic       last_s;
  logic [3:0] cnt_inc_s;
  logic [2:0] next_idx_s;

  // Synchronise the request level into sdram_clk.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_r <= 1'b0;
      req0_r     <= 1'b0;
      req1_r     <= 1'b0;
    end else begin
      req_meta_r <= qspi_wr_req;
      req0_r     <= req_meta_r;
      req1_r     <= req0_r;
    end
  end

  assign start_s = req0_r & ~req1_r;

`ifdef WR_LEN_EN
  logic [3:0] len_r;

  // Capture the requested length together with the address.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && start_s) begin
      len_r <= qspi_wr_len;
    end
  end

  // Zero or out-of-range lengths fall back to a full buffer.
  always_comb begin
    if ((len_r == 4'd0) || (len_r > 4'd8)) begin
      bl_s = 4'd8;
    end else begin
      bl_s = len_r;
    end
  end
`else
  assign bl_s = 4'(WR_BL);
`endif

  assign beat_s     = wr_valid & wr_ready;
  assign last_s     = (wr_cnt_r == (bl_s - 4'd1));
  assign cnt_inc_s  = wr_cnt_r + 4'd1;
  assign next_idx_s = cnt_inc_s[2:0];

  // Staging buffer: writes are only honoured while idle so the burst image
  // is frozen from the moment the request is taken.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        buf_r[i] <= 16'd0;
      end
    end else if ((state_r == ST_IDLE) && buf_wen) begin
      buf_r[buf_waddr] <= buf_wdata;
    end
  end

  // Burst FSM with all outputs registered alongside the state.
  // wr_data is preloaded with word 0 before the data phase and advanced to
  // the next word on every accepted beat, so it holds during stalls.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wr_cnt_r     <= 4'd0;
      wr_addr      <= 24'd0;
      wr_avalid    <= 1'b0;
      wr_valid     <= 1'b0;
      wr_data      <= 16'd0;
      qspi_wr_busy <= 1'b0;
      wr_done      <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wr_cnt_r <= 4'd0;
          wr_data  <= buf_r[3'd0];
          if (start_s) begin
            // Byte address to 16-bit word address.
            wr_addr      <= {1'b0, qspi_wr_addr[23:1]};
            wr_avalid    <= 1'b1;
            qspi_wr_busy <= 1'b1;
            state_r      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          wr_cnt_r <= 4'd0;
          wr_data  <= buf_r[3'd0];
          if (wr_avalid && wr_aready) begin
            wr_avalid <= 1'b0;
            wr_valid  <= 1'b1;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_s) begin
            if (last_s) begin
              wr_cnt_r     <= 4'd0;
              wr_valid     <= 1'b0;
              wr_data      <= buf_r[3'd0];
              qspi_wr_busy <= 1'b0;
              wr_done      <= 1'b1;
              state_r      <= ST_IDLE;
            end else begin
              wr_cnt_r <= cnt_inc_s;
              wr_data  <= buf_r[next_idx_s];
            end
          end
        end
        default: begin
          wr_cnt_r     <= 4'd0;
          wr_avalid    <= 1'b0;
          wr_valid     <= 1'b0;
          wr_data      <= 16'd0;
          qspi_wr_busy <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wr_sdram.sv
// tb_ram_wr_sdram
// Directed and randomized bursts against a reference model that tracks the
// staging buffer contents and the expected beat sequence per burst.
module tb_ram_wr_sdram;

  logic        clk;
  logic        rst_n;
  logic        buf_wen;
  logic [2:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic        qspi_wr_req;
  logic [23:0] qspi_wr_addr;
  logic [3:0]  qspi_wr_len;
  logic        qspi_wr_busy;
  logic        wr_done;
  logic [23:0] wr_addr;
  logic        wr_avalid;
  logic        wr_aready;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference image of the staging buffer.
  logic [15:0] model_buf [8];

  ram_wr_sdram #(.WR_BL(8)) dut (
    .sdram_clk   (clk),
    .rst_n       (rst_n),
    .buf_wen     (buf_wen),
    .buf_waddr   (buf_waddr),
    .buf_wdata   (buf_wdata),
    .qspi_wr_req (qspi_wr_req),
    .qspi_wr_addr(qspi_wr_addr),
`ifdef WR_LEN_EN
    .qspi_wr_len (qspi_wr_len),
`endif
    .qspi_wr_busy(qspi_wr_busy),
    .wr_done     (wr_done),
    .wr_addr     (wr_addr),
    .wr_avalid   (wr_avalid),
    .wr_aready   (wr_aready),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(qspi_wr_busy), 32'd0);
    chk({tag, "_done"},   32'(wr_done),      32'd0);
    chk({tag, "_addr"},   32'(wr_addr),      32'd0);
    chk({tag, "_avalid"}, 32'(wr_avalid),    32'd0);
    chk({tag, "_data"},   32'(wr_data),      32'd0);
    chk({tag, "_valid"},  32'(wr_valid),     32'd0);
  endtask

  // Fill all eight words (sequential from base, or random) while idle.
  task automatic fill(input bit rnd, input logic [15:0] base);
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d = rnd ? 16'($urandom) : base + 16'(i);
      buf_wen   = 1'b1;
      buf_waddr = 3'(i);
      buf_wdata = d;
      model_buf[i] = d;
    end
    @(negedge clk);
    buf_wen = 1'b0;
  endtask

  // One request/burst. mode: 0 ready high, 1 wr_ready toggles, 2 random.
  // opt: 0 none, 1 buffer write during data phase, 2 second request edge
  // during the burst, 3 buffer write in the same cycle as start.
  // abort_beat > 0: pull reset after that many beats were accepted.
  task automatic do_burst(input logic [23:0] addr, input int mode, input int opt,
                          input logic [3:0] len, input int abort_beat);
    int c, beats, bl;
    bit addr_done, exp_done, finished, tog, rdy, ardy, in_data;
    logic [23:0] exp_waddr;
    logic [15:0] d;
    bl = 8;
`ifdef WR_LEN_EN
    bl = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
`endif
    exp_waddr = {1'b0, addr[23:1]};
    c = 0; beats = 0; addr_done = 0; exp_done = 0; finished = 0; tog = 1'b0;
    @(negedge clk);
    qspi_wr_req  = 1'b1;
    qspi_wr_addr = addr;
    qspi_wr_len  = len;
    while (!finished && c < 400) begin
      @(negedge clk);
      c++;
      buf_wen = 1'b0;
      in_data = addr_done && (beats < bl);
      chk("wr_done", 32'(wr_done), 32'(exp_done));
      chk("busy", 32'(qspi_wr_busy), 32'((c >= 3) && !exp_done));
      chk("avalid", 32'(wr_avalid), 32'((c >= 3) && !addr_done && !exp_done));
      chk("valid", 32'(wr_valid), 32'(in_data));
      if (exp_done) begin
        finished = 1;
        if (mode == 0) chk("burst_cycles", 32'(c), 32'(4 + bl));
      end else if (abort_beat > 0 && in_data && beats == abort_beat) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model_buf[i] = 16'd0;
        exp_waddr = 24'd0;
        finished = 1;
      end else begin
        case (mode)
          0: begin rdy = 1'b1; ardy = 1'b1; end
          1: begin tog = ~tog; rdy = tog; ardy = 1'b1; end
          default: begin rdy = ($urandom_range(0, 3) != 0); ardy = 1'($urandom_range(0, 1)); end
        endcase
        wr_ready  = rdy;
        wr_aready = ardy;
        if (opt == 3 && c == 2) begin
          d = 16'($urandom);
          buf_wen = 1'b1; buf_waddr = 3'd5; buf_wdata = d;
          model_buf[5] = d;
        end
        if (opt == 1 && in_data && beats == 1) begin
          buf_wen = 1'b1; buf_waddr = 3'd3; buf_wdata = 16'hDEAD;
        end
        if (opt == 2 && in_data && beats == 1) begin
          qspi_wr_req = 1'b0;
          qspi_wr_addr = addr ^ 24'h555554;
        end
        if (opt == 2 && in_data && beats == 2) qspi_wr_req = 1'b1;
        if (c >= 3 && !addr_done) begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_waddr));
          if (ardy) addr_done = 1;
        end else if (in_data && rdy) begin
          chk("beat_data", 32'(wr_data), 32'(model_buf[beats]));
          beats++;
          if (beats == bl) exp_done = 1;
        end
      end
    end
    if (!finished) chk("burst_timeout", 32'd0, 32'd1);
    qspi_wr_req = 1'b0;
    wr_ready = 1'b0;
    wr_aready = 1'b0;
    buf_wen = 1'b0;
    // Quiet period: no spurious burst, address held, counter parked at 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_busy",   32'(qspi_wr_busy), 32'd0);
      chk("post_avalid", 32'(wr_avalid),    32'd0);
      chk("post_done",   32'(wr_done),      32'd0);
      chk("post_addr",   32'(wr_addr),      32'(exp_waddr));
    end
    chk("wr_cnt_end", 32'(dut.wr_cnt_r), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; buf_wen = 1'b0; buf_waddr = 3'd0; buf_wdata = 16'd0;
    qspi_wr_req = 1'b0; qspi_wr_addr = 24'd0; qspi_wr_len = 4'd0;
    wr_aready = 1'b0; wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) model_buf[i] = 16'd0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    // Basic burst, no back-pressure.
    fill(1'b0, 16'h1000);
    do_burst(24'h000100, 0, 0, 4'd0, 0);
    // Same burst, wr_ready toggling.
    do_burst(24'h000100, 1, 0, 4'd0, 0);
    // Buffer write during data phase is dropped; next burst keeps old word 3.
    do_burst(24'h012346, 0, 1, 4'd0, 0);
    do_burst(24'h012346, 0, 0, 4'd0, 0);
    // Second request edge during a burst is ignored.
    do_burst(24'hABCDEF, 0, 2, 4'd0, 0);
    // Same-cycle buffer write and start is part of the burst.
    do_burst(24'h000202, 0, 3, 4'd0, 0);
    // Reset at beat 4, then a full burst of the cleared buffer.
    do_burst(24'h00F000, 0, 0, 4'd0, 4);
    do_burst(24'h00F000, 0, 0, 4'd0, 0);
`ifdef WR_LEN_EN
    fill(1'b1, 16'd0);
    do_burst(24'h000010, 0, 0, 4'd3, 0);
    do_burst(24'h000010, 2, 0, 4'd0, 0);
    do_burst(24'h000010, 2, 0, 4'd12, 0);
`endif
    // Randomized contents, addresses and handshake back-pressure.
    for (int k = 0; k < 6; k++) begin
      fill(1'b1, 16'd0);
      do_burst(24'($urandom), 2, 0, 4'($urandom_range(0, 15)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
